// File: rtl/coax_rx_bit_timer.sv
// coax_rx_bit_timer: receive-side bi-phase (Manchester) bit timing recovery.
// Locks onto mid-bit transitions, resyncs on each one and emits one strobe
// per recovered bit. Flags missing mid-bit transitions and drops lock after
// two consecutive misses.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high reset
//   rx               line input, already synchronized to clk
//   active           high while locked to an incoming bit stream
//   bit_strobe       one-cycle pulse per recovered bit
//   bit_value        recovered bit (line level after mid-bit transition)
//   violation_strobe one-cycle pulse on a missing mid-bit transition
//   loss_strobe      one-cycle pulse on lock loss (return to IDLE)
//
// Optional build macro: COAX_RX_BIT_TIMER_DEGLITCH_EN
//   Adds a filter stage that rejects single-cycle rx pulses (+1 clk latency).

module coax_rx_bit_timer #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic active,
    output logic bit_strobe,
    output logic bit_value,
    output logic violation_strobe,
    output logic loss_strobe
);

    localparam int CW = $clog2(2 * CLOCKS_PER_BIT) + 1;

    // Mid-bit acceptance window and flywheel reload value.
    localparam logic [CW-1:0] WIN_LO  = CW'(3 * CLOCKS_PER_BIT / 4);
    localparam logic [CW-1:0] WIN_HI  = CW'(3 * CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FLY = CW'(CLOCKS_PER_BIT / 2);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t state_q, state_d;

    logic          rx_d_q;
    logic          rx_q_q;
    logic          lvl;
    logic          edge_seen;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    miss_q, miss_d;
    logic          active_q, active_d;
    logic          bstb_q, bstb_d;
    logic          bval_q, bval_d;
    logic          viol_q, viol_d;
    logic          loss_q, loss_d;

    logic          mid_ok;
    logic          timeout;

    // ---------------------------------------------------------------
    // Edge detection
    // ---------------------------------------------------------------
`ifdef COAX_RX_BIT_TIMER_DEGLITCH_EN
    logic rx_f_q;

    // rx_f follows rx_d only once rx_d has been stable for two clocks,
    // so a single-cycle pulse on rx never reaches the edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_d_q <= 1'b0;
            rx_f_q <= 1'b0;
            rx_q_q <= 1'b0;
        end else begin
            rx_d_q <= rx;
            if (rx == rx_d_q) begin
                rx_f_q <= rx_d_q;
            end
            rx_q_q <= rx_f_q;
        end
    end

    assign lvl = rx_f_q;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_d_q <= 1'b0;
            rx_q_q <= 1'b0;
        end else begin
            rx_d_q <= rx;
            rx_q_q <= rx_d_q;
        end
    end

    assign lvl = rx_d_q;
`endif

    assign edge_seen = (lvl != rx_q_q);

    // The counter never exceeds WIN_HI while locked, so only the lower
    // bound of the window needs checking. An edge on the timeout cycle
    // lands inside the window and therefore wins over the flywheel.
    assign mid_ok  = edge_seen && (cnt_q >= WIN_LO);
    assign timeout = (cnt_q == WIN_HI);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (edge_seen) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!mid_ok && timeout && (miss_q == 2'd1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output / datapath next values
    // ---------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        miss_d   = miss_q;
        active_d = active_q;
        bstb_d   = 1'b0;
        bval_d   = bval_q;
        viol_d   = 1'b0;
        loss_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                miss_d = '0;
                // First edge after idle is taken as a mid-bit transition.
                if (edge_seen) begin
                    active_d = 1'b1;
                    bstb_d   = 1'b1;
                    bval_d   = lvl;
                end
            end
            LOCKED: begin
                if (mid_ok) begin
                    bstb_d = 1'b1;
                    bval_d = lvl;
                    cnt_d  = '0;
                    miss_d = '0;
                end else if (timeout) begin
                    viol_d = 1'b1;
                    if (miss_q == 2'd1) begin
                        active_d = 1'b0;
                        loss_d   = 1'b1;
                        cnt_d    = '0;
                        miss_d   = '0;
                    end else begin
                        // Continue as if a mid-bit had occurred at c=C.
                        cnt_d  = CNT_FLY;
                        miss_d = miss_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d  = '0;
                miss_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            miss_q   <= '0;
            active_q <= 1'b0;
            bstb_q   <= 1'b0;
            bval_q   <= 1'b0;
            viol_q   <= 1'b0;
            loss_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            active_q <= active_d;
            bstb_q   <= bstb_d;
            bval_q   <= bval_d;
            viol_q   <= viol_d;
            loss_q   <= loss_d;
        end
    end

    assign active           = active_q;
    assign bit_strobe       = bstb_q;
    assign bit_value        = bval_q;
    assign violation_strobe = viol_q;
    assign loss_strobe      = loss_q;

endmodule

// File: tb/tb_coax_rx_bit_timer.sv
// tb_coax_rx_bit_timer: directed bench for coax_rx_bit_timer.
// Expected strobe events are queued as rx is driven and matched on output.

module tb_coax_rx_bit_timer;

    localparam int C = 8;
`ifdef COAX_RX_BIT_TIMER_DEGLITCH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic active;
    logic bit_strobe;
    logic bit_value;
    logic violation_strobe;
    logic loss_strobe;

    // kind = {loss, violation, bit}
    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic       val;
    } exp_t;

    exp_t exp_q[$];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int ref_c = 0;

    coax_rx_bit_timer #(
        .CLOCKS_PER_BIT(C)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .active          (active),
        .bit_strobe      (bit_strobe),
        .bit_value       (bit_value),
        .violation_strobe(violation_strobe),
        .loss_strobe     (loss_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $error("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        logic [2:0] ok;
        logic       ov;
        exp_t       e;
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                tests++;
                assert (0) else begin
                    fails++;
                    $error("FAIL missing: got none expected kind %b at cyc %0d",
                           e.kind, e.cyc);
                end
            end
            ok = {loss_strobe, violation_strobe, bit_strobe};
            ov = bit_strobe ? bit_value : 1'b0;
            if (ok != 3'b000) begin
                tests++;
                assert (!(bit_strobe && violation_strobe)) else begin
                    fails++;
                    $error("FAIL excl: got bit+viol expected one at cyc %0d", cyc);
                end
                if (exp_q.size() == 0) begin
                    tests++;
                    assert (ok === 3'b000) else begin
                        fails++;
                        $error("FAIL unexpected: got kind %b expected none at cyc %0d",
                               ok, cyc);
                    end
                end else begin
                    e = exp_q.pop_front();
                    tests++;
                    assert ({cyc, ok, ov} === {e.cyc, e.kind, e.val}) else begin
                        fails++;
                        $error("FAIL event: got cyc %0d kind %b val %b expected cyc %0d kind %b val %b",
                               cyc, ok, ov, e.cyc, e.kind, e.val);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".active"}, int'(active), 0);
        chk({tag, ".bstb"}, int'(bit_strobe), 0);
        chk({tag, ".bval"}, int'(bit_value), 0);
        chk({tag, ".viol"}, int'(violation_strobe), 0);
        chk({tag, ".loss"}, int'(loss_strobe), 0);
    endtask

    task automatic wait_cyc(input int n);
        if (cyc > n) begin
            fails++;
            $error("FAIL sched: got cyc %0d expected <= %0d", cyc, n);
        end
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [2:0] k, input logic v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // First edge from IDLE.
    task automatic lock(input logic v);
        int j;
        j = cyc + 1;
        wait_cyc(j);
        rx = v;
        ref_c = j + LAT;
        push(ref_c, 3'b001, v);
    endtask

    // Mid-bit edge seen at counter value c.
    task automatic mid(input int c, input logic v);
        wait_cyc(ref_c + c + 1 - LAT);
        rx = v;
        ref_c = ref_c + c + 1;
        push(ref_c, 3'b001, v);
    endtask

    // Cell-boundary edge seen at counter value c.
    task automatic bnd(input int c);
        wait_cyc(ref_c + c + 1 - LAT);
        rx = ~rx;
    endtask

    // Missed mid-bit: violation at c=3C/2-1, virtual mid-bit at c=C.
    task automatic miss();
        push(ref_c + 3 * C / 2, 3'b010, 1'b0);
        ref_c = ref_c + C;
    endtask

    task automatic lose();
        ref_c = ref_c + 3 * C / 2;
        push(ref_c, 3'b110, 1'b0);
    endtask

    initial begin
        rx    = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst0");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            rx = ~rx;
            chk_zero("rst_tgl");
        end
        rx = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cyc(cyc + 12);
        chk("idle_active", int'(active), 0);

        // Clean stream 1,0,1,1.
        lock(1'b1);
        wait_cyc(ref_c);
        chk("lock_active", int'(active), 1);
        mid(7, 1'b0);
        mid(7, 1'b1);
        bnd(3);
        mid(7, 1'b1);

        // Jitter at both window edges.
        mid(6, 1'b0);
        mid(11, 1'b1);

        // Single miss, then recovery.
        miss();
        mid(8, 1'b0);
        wait_cyc(ref_c);
        chk("miss_active", int'(active), 1);

        // Miss count must have cleared: another single miss is no loss.
        miss();
        mid(8, 1'b1);

        // Line goes quiet: violation, then violation+loss.
        miss();
        lose();
        wait_cyc(ref_c);
        chk("loss_active", int'(active), 0);
        lock(1'b0);
        mid(7, 1'b1);

        // Reset 4 clocks into a cell.
        wait_cyc(ref_c + 4);
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cyc(cyc + 6);
        chk("post_rst_active", int'(active), 0);
        lock(1'b1);
        wait_cyc(ref_c);
        chk("relock_active", int'(active), 1);

`ifdef COAX_RX_BIT_TIMER_DEGLITCH_EN
        // One-clock pulse inside the window must be filtered out.
        wait_cyc(ref_c + 8 + 1 - LAT);
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        mid(10, 1'b0);
`else
        mid(7, 1'b0);
`endif

        wait_cyc(ref_c + 4);
        chk("end_active", int'(active), 1);
        chk("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
